// File: rtl/fetch_pkg.sv
// Shared types and bus tag constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} fetch_state_t;

  localparam logic       READ    = 1'b1;
  localparam logic [3:0] MEMORY  = 4'b0001;
  localparam logic [12:0] REQ_TAG = {READ, MEMORY, 8'b0};

endpackage

// File: rtl/fetch_byte_ring.sv
// Circular byte store: writes one beat per cycle minus a leading-byte drop count,
// and exposes a wrapped window of bytes starting at the read pointer.
module fetch_byte_ring #(
  parameter int BUF_BYTES    = 128,
  parameter int BEAT_BYTES   = 8,
  parameter int WINDOW_BYTES = 15,
  parameter int PTR_W        = $clog2(BUF_BYTES),
  parameter int LEAD_W       = $clog2(BEAT_BYTES) + 1
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [PTR_W-1:0]          wr_ptr,
  input  logic [LEAD_W-1:0]         wr_lead,
  input  logic [8*BEAT_BYTES-1:0]   wr_data,
  input  logic [PTR_W-1:0]          rd_ptr,
  output logic [8*WINDOW_BYTES-1:0] win_bytes
);

  logic [7:0]       mem [BUF_BYTES];
  logic [PTR_W-1:0] wr_idx [BEAT_BYTES];
  logic [BEAT_BYTES-1:0] wr_keep;

  // Kept bytes are packed down so the first kept byte lands at wr_ptr.
  for (genvar gi = 0; gi < BEAT_BYTES; gi++) begin : g_wr
    assign wr_idx[gi]  = wr_ptr + PTR_W'(gi) - PTR_W'(wr_lead);
    assign wr_keep[gi] = wr_en && (LEAD_W'(gi) >= wr_lead);
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < BEAT_BYTES; k++) begin
      if (wr_keep[k]) begin
        mem[wr_idx[k]] <= wr_data[8*BEAT_BYTES-1-8*k -: 8];
      end
    end
  end

  for (genvar gi = 0; gi < WINDOW_BYTES; gi++) begin : g_win
    assign win_bytes[8*WINDOW_BYTES-1-8*gi -: 8] = mem[rd_ptr + PTR_W'(gi)];
  end

endmodule

// File: rtl/fetch_stream_buffer.sv
// Fetch front end: line requests on the bus, beat routing with entry skip,
// ring occupancy tracking and redirect with drain of the in-flight line.
module fetch_stream_buffer
  import fetch_pkg::*;
#(
  parameter int BUF_BYTES    = 128,
  parameter int LINE_BYTES   = 64,
  parameter int BEAT_BYTES   = 8,
  parameter int WINDOW_BYTES = 15,
  parameter int TAG_W        = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  input  logic                      redirect,
  input  logic [63:0]               redirect_addr,
  output logic                      reqcyc,
  input  logic                      reqack,
  output logic [63:0]               req,
  output logic [TAG_W-1:0]          reqtag,
  input  logic                      respcyc,
  output logic                      respack,
  input  logic [8*BEAT_BYTES-1:0]   resp,
  output logic [8*WINDOW_BYTES-1:0] win_bytes,
  output logic [3:0]                win_count,
  output logic [63:0]               win_addr,
  input  logic [3:0]                consume
);

  localparam int PTR_W   = $clog2(BUF_BYTES);
  localparam int CNT_W   = $clog2(BUF_BYTES) + 1;
  localparam int OFF_W   = $clog2(LINE_BYTES);
  localparam int BEATS   = LINE_BYTES / BEAT_BYTES;
  localparam int BC_W    = $clog2(BEATS);
  localparam int BEAT_SH = $clog2(BEAT_BYTES);
  localparam int LEAD_W  = BEAT_SH + 1;
  localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);

  fetch_state_t     state_reg;
  logic             reqcyc_reg;
  logic [63:0]      req_reg;
  logic [63:0]      fetch_line_reg;
  logic [OFF_W-1:0] skip_reg;
  logic [BC_W-1:0]  beat_cnt_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [63:0]      win_addr_reg;
  logic             drain_pending_reg;

  logic [OFF_W:0]   beat_lo;
  logic [OFF_W:0]   beat_hi;
  logic [OFF_W:0]   skip_ext;
  logic             beat_in;
  logic             beat_keep;
  logic             last_beat;
  logic             free_ok;
  logic [LEAD_W-1:0] lead;
  logic [CNT_W-1:0] written;

  assign beat_lo   = (OFF_W+1)'({beat_cnt_reg, {BEAT_SH{1'b0}}});
  assign beat_hi   = beat_lo + (OFF_W+1)'(BEAT_BYTES);
  assign skip_ext  = {1'b0, skip_reg};
  assign beat_in   = (state_reg == RESP) && respcyc && !redirect;
  assign beat_keep = beat_in && (beat_hi > skip_ext);
  assign lead      = (beat_lo < skip_ext) ? LEAD_W'(skip_ext - beat_lo) : '0;
  assign written   = beat_keep ? (CNT_W'(BEAT_BYTES) - CNT_W'(lead)) : '0;
  assign last_beat = (beat_cnt_reg == BC_W'(BEATS - 1));
  assign free_ok   = (CNT_W'(BUF_BYTES) - count_reg) >= CNT_W'(LINE_BYTES);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      reqcyc_reg        <= 1'b0;
      req_reg           <= '0;
      fetch_line_reg    <= entry & LINE_MASK;
      skip_reg          <= entry[OFF_W-1:0];
      beat_cnt_reg      <= '0;
      count_reg         <= '0;
      rd_ptr_reg        <= '0;
      wr_ptr_reg        <= '0;
      win_addr_reg      <= entry;
      drain_pending_reg <= 1'b0;
    end else begin
      if (redirect) begin
        count_reg      <= '0;
        rd_ptr_reg     <= '0;
        wr_ptr_reg     <= '0;
        win_addr_reg   <= redirect_addr;
        fetch_line_reg <= redirect_addr & LINE_MASK;
        skip_reg       <= redirect_addr[OFF_W-1:0];
      end else begin
        count_reg    <= count_reg + written - CNT_W'(consume);
        rd_ptr_reg   <= rd_ptr_reg + PTR_W'(consume);
        wr_ptr_reg   <= wr_ptr_reg + PTR_W'(written);
        win_addr_reg <= win_addr_reg + 64'(consume);
      end

      case (state_reg)
        IDLE: begin
          if (!redirect && free_ok) begin
            state_reg  <= REQ;
            reqcyc_reg <= 1'b1;
            req_reg    <= fetch_line_reg;
          end
        end
        REQ: begin
          // A redirect during the request phase still owns the line once acked.
          if (redirect) drain_pending_reg <= 1'b1;
          if (reqack) begin
            reqcyc_reg        <= 1'b0;
            beat_cnt_reg      <= '0;
            drain_pending_reg <= 1'b0;
            state_reg         <= (redirect || drain_pending_reg) ? DRAIN : RESP;
          end
        end
        RESP: begin
          if (respcyc) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (last_beat) begin
              state_reg <= IDLE;
              if (!redirect) begin
                fetch_line_reg <= fetch_line_reg + 64'(LINE_BYTES);
                skip_reg       <= '0;
              end
            end else if (redirect) begin
              state_reg <= DRAIN;
            end
          end else if (redirect) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (respcyc) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (last_beat) state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  fetch_byte_ring #(
    .BUF_BYTES    (BUF_BYTES),
    .BEAT_BYTES   (BEAT_BYTES),
    .WINDOW_BYTES (WINDOW_BYTES),
    .PTR_W        (PTR_W),
    .LEAD_W       (LEAD_W)
  ) u_ring (
    .clk       (clk),
    .wr_en     (beat_keep),
    .wr_ptr    (wr_ptr_reg),
    .wr_lead   (lead),
    .wr_data   (resp),
    .rd_ptr    (rd_ptr_reg),
    .win_bytes (win_bytes)
  );

  assign reqcyc    = reqcyc_reg;
  assign req       = req_reg;
  assign reqtag    = TAG_W'(REQ_TAG);
  assign respack   = respcyc;
  assign win_addr  = win_addr_reg;
  assign win_count = (count_reg >= CNT_W'(WINDOW_BYTES)) ? 4'(WINDOW_BYTES) : 4'(count_reg);

  assert property (@(posedge clk) disable iff (reset) consume <= win_count)
    else $fatal(1, "consume exceeds win_count");
  assert property (@(posedge clk) disable iff (reset)
                   respcyc |-> (state_reg == RESP || state_reg == DRAIN))
    else $error("response beat with no line outstanding");

endmodule

// File: tb/tb_fetch_stream_buffer.sv
// Directed bench for fetch_stream_buffer with an inline bus/memory model.
module tb_fetch_stream_buffer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [63:0]  entry = 64'h0;
  logic         redirect = 1'b0;
  logic [63:0]  redirect_addr = 64'h0;
  logic         reqcyc;
  logic         reqack = 1'b0;
  logic [63:0]  req;
  logic [12:0]  reqtag;
  logic         respcyc = 1'b0;
  logic         respack;
  logic [63:0]  resp = 64'h0;
  logic [119:0] win_bytes;
  logic [3:0]   win_count;
  logic [63:0]  win_addr;
  logic [3:0]   consume = 4'd0;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stream_buffer dut (
    .clk(clk), .reset(reset), .entry(entry), .redirect(redirect),
    .redirect_addr(redirect_addr), .reqcyc(reqcyc), .reqack(reqack), .req(req),
    .reqtag(reqtag), .respcyc(respcyc), .respack(respack), .resp(resp),
    .win_bytes(win_bytes), .win_count(win_count), .win_addr(win_addr),
    .consume(consume)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mb(input logic [63:0] a);
    return a[7:0] ^ {a[9:8], a[9:8], a[9:8], a[9:8]} ^ 8'hA5;
  endfunction

  function automatic logic [63:0] beat_data(input logic [63:0] line, input int i);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[63-8*k -: 8] = mb(line + 64'(i*8 + k));
    return d;
  endfunction

  function automatic logic [7:0] wb(input int k);
    return win_bytes[119-8*k -: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [63:0] e);
    reset = 1'b1; entry = e; respcyc = 1'b0; reqack = 1'b0; consume = 4'd0; redirect = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic wait_req(output bit ok, output logic [63:0] addr);
    for (int i = 0; i < 50 && !reqcyc; i++) step();
    ok = reqcyc;
    addr = req;
  endtask

  task automatic ack_req();
    reqack = 1'b1; step(); reqack = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] line, input int i);
    respcyc = 1'b1; resp = beat_data(line, i); step(); respcyc = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; entry = 64'h1000; step(); step();
    n_tests++; if (reqcyc !== 1'b0) begin n_fail++; $display("FAIL reset_reqcyc got=%0b want=0", reqcyc); end
    n_tests++; if (win_count !== 4'd0) begin n_fail++; $display("FAIL reset_win_count got=%0d want=0", win_count); end
    n_tests++; if (win_addr !== 64'h1000) begin n_fail++; $display("FAIL reset_win_addr got=%h want=1000", win_addr); end
    n_tests++; if (req !== 64'h0) begin n_fail++; $display("FAIL reset_req got=%h want=0", req); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_first_line();
    bit ok; logic [63:0] a;
    reset = 1'b0;
    wait_req(ok, a);
    n_tests++; if (!ok || a !== 64'h1000) begin n_fail++; $display("FAIL first_req got=%h ok=%0b want=1000", a, ok); end
    n_tests++; if (reqtag !== 13'h1100) begin n_fail++; $display("FAIL reqtag got=%h want=1100", reqtag); end
    step(); step();
    n_tests++; if (reqcyc !== 1'b1) begin n_fail++; $display("FAIL reqcyc_hold got=%0b want=1", reqcyc); end
    ack_req();
    n_tests++; if (reqcyc !== 1'b0) begin n_fail++; $display("FAIL reqcyc_drop got=%0b want=0", reqcyc); end
    for (int i = 0; i < 8; i++) send_beat(64'h1000, i);
    n_tests++; if (dut.count_reg !== 8'd64) begin n_fail++; $display("FAIL line1_count got=%0d want=64", dut.count_reg); end
    n_tests++; if (win_count !== 4'd15) begin n_fail++; $display("FAIL line1_win_count got=%0d want=15", win_count); end
    n_tests++; if (win_addr !== 64'h1000) begin n_fail++; $display("FAIL line1_win_addr got=%h want=1000", win_addr); end
    n_tests++; if (wb(0) !== mb(64'h1000) || wb(14) !== mb(64'h100E))
      begin n_fail++; $display("FAIL line1_bytes got=%h/%h want=%h/%h", wb(0), wb(14), mb(64'h1000), mb(64'h100E)); end
    $display("[TB] test_first_line done");
  endtask

  task automatic test_fill_no_consume();
    bit ok; logic [63:0] a; int extra;
    wait_req(ok, a);
    n_tests++; if (!ok || a !== 64'h1040) begin n_fail++; $display("FAIL second_req got=%h ok=%0b want=1040", a, ok); end
    ack_req();
    for (int i = 0; i < 8; i++) send_beat(64'h1040, i);
    n_tests++; if (dut.count_reg !== 8'd128) begin n_fail++; $display("FAIL full_count got=%0d want=128", dut.count_reg); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin if (reqcyc) extra++; step(); end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL full_no_req got=%0d want=0", extra); end
    n_tests++; if (wb(0) !== mb(64'h1000)) begin n_fail++; $display("FAIL full_byte0 got=%h want=%h", wb(0), mb(64'h1000)); end
    $display("[TB] test_fill_no_consume done");
  endtask

  task automatic test_unaligned_entry();
    bit ok; logic [63:0] a;
    do_reset(64'h1013);
    wait_req(ok, a);
    n_tests++; if (!ok || a !== 64'h1000) begin n_fail++; $display("FAIL skip_req got=%h ok=%0b want=1000", a, ok); end
    ack_req();
    for (int i = 0; i < 8; i++) send_beat(64'h1000, i);
    n_tests++; if (dut.count_reg !== 8'd45) begin n_fail++; $display("FAIL skip_count got=%0d want=45", dut.count_reg); end
    n_tests++; if (win_addr !== 64'h1013) begin n_fail++; $display("FAIL skip_win_addr got=%h want=1013", win_addr); end
    n_tests++; if (wb(0) !== mb(64'h1013) || wb(5) !== mb(64'h1018))
      begin n_fail++; $display("FAIL skip_bytes got=%h/%h want=%h/%h", wb(0), wb(5), mb(64'h1013), mb(64'h1018)); end
    $display("[TB] test_unaligned_entry done");
  endtask

  task automatic test_redirect();
    bit ok; logic [63:0] a; int stray;
    do_reset(64'h1000);
    wait_req(ok, a);
    ack_req();
    for (int i = 0; i < 4; i++) send_beat(64'h1000, i);
    redirect = 1'b1; redirect_addr = 64'h2004;
    send_beat(64'h1000, 4);
    redirect = 1'b0;
    n_tests++; if (dut.count_reg !== 8'd0 || win_count !== 4'd0)
      begin n_fail++; $display("FAIL redir_count got=%0d/%0d want=0/0", dut.count_reg, win_count); end
    n_tests++; if (win_addr !== 64'h2004) begin n_fail++; $display("FAIL redir_win_addr got=%h want=2004", win_addr); end
    stray = 0;
    for (int i = 5; i < 8; i++) begin if (reqcyc) stray++; send_beat(64'h1000, i); end
    n_tests++; if (stray !== 0 || dut.count_reg !== 8'd0)
      begin n_fail++; $display("FAIL drain got=req%0d/count%0d want=0/0", stray, dut.count_reg); end
    wait_req(ok, a);
    n_tests++; if (!ok || a !== 64'h2000) begin n_fail++; $display("FAIL redir_req got=%h ok=%0b want=2000", a, ok); end
    ack_req();
    for (int i = 0; i < 8; i++) send_beat(64'h2000, i);
    n_tests++; if (dut.count_reg !== 8'd60 || wb(0) !== mb(64'h2004))
      begin n_fail++; $display("FAIL redir_line got=%0d/%h want=60/%h", dut.count_reg, wb(0), mb(64'h2004)); end
    $display("[TB] test_redirect done");
  endtask

  task automatic test_stream();
    logic [63:0] exp_addr, line;
    int consumed, bad, cycles, beat_i;
    bit inflight;
    int wc;
    do_reset(64'h1000);
    exp_addr = 64'h1000; consumed = 0; bad = 0; cycles = 0; inflight = 0; beat_i = 0; line = '0;
    while (consumed < 600 && cycles < 4000) begin
      wc = int'(win_count);
      if (win_addr !== exp_addr) bad++;
      for (int j = 0; j < wc; j++) if (wb(j) !== mb(exp_addr + 64'(j))) bad++;
      consume = win_count;
      exp_addr += 64'(wc);
      consumed += wc;
      reqack = 1'b0; respcyc = 1'b0;
      if (inflight) begin
        respcyc = 1'b1; resp = beat_data(line, beat_i); beat_i++;
        if (beat_i == 8) inflight = 0;
      end else if (reqcyc) begin
        reqack = 1'b1; line = req; inflight = 1; beat_i = 0;
      end
      step();
      cycles++;
    end
    consume = 4'd0; reqack = 1'b0; respcyc = 1'b0;
    n_tests++; if (consumed < 600) begin n_fail++; $display("FAIL stream_timeout got=%0d want>=600", consumed); end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL stream_bytes got=%0d_errors want=0", bad); end
    $display("[TB] test_stream done: %0d bytes in %0d cycles", consumed, cycles);
  endtask

  task automatic test_reset_mid_resp();
    bit ok; logic [63:0] a;
    do_reset(64'h1000);
    wait_req(ok, a);
    ack_req();
    for (int i = 0; i < 3; i++) send_beat(64'h1000, i);
    reset = 1'b1; entry = 64'h3008;
    step();
    n_tests++; if (reqcyc !== 1'b0 || dut.count_reg !== 8'd0 || win_count !== 4'd0)
      begin n_fail++; $display("FAIL midreset got=%0b/%0d/%0d want=0/0/0", reqcyc, dut.count_reg, win_count); end
    reset = 1'b0;
    wait_req(ok, a);
    n_tests++; if (!ok || a !== 64'h3000) begin n_fail++; $display("FAIL midreset_req got=%h ok=%0b want=3000", a, ok); end
    ack_req();
    for (int i = 0; i < 8; i++) send_beat(64'h3000, i);
    n_tests++; if (dut.count_reg !== 8'd56 || wb(0) !== mb(64'h3008) || win_addr !== 64'h3008)
      begin n_fail++; $display("FAIL midreset_line got=%0d/%h/%h want=56/%h/3008", dut.count_reg, wb(0), win_addr, mb(64'h3008)); end
    $display("[TB] test_reset_mid_resp done");
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_fill_no_consume();
    test_unaligned_entry();
    test_redirect();
    test_stream();
    test_reset_mid_resp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
